// File: rtl/block_store_pkg.sv
// Shared constants, row type and reload FSM states for the block map.
// Used by block_state_store and blocks_painter.
package block_store_pkg;

    localparam int BLOCKS_PER_ROW = 13;
    localparam int NUM_ROWS       = 16;
    localparam int ROW_IDX_W      = 4;

    typedef logic [BLOCKS_PER_ROW-1:0] row_t;
    typedef logic [ROW_IDX_W-1:0]      row_idx_t;

    localparam row_t       FULL_ROW     = 13'h1FFF;
    localparam logic [7:0] TOTAL_BLOCKS = 8'd208;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FILL
    } fsm_t;

endpackage

// File: rtl/block_state_store_if.sv
// Line-state link between blocks_painter (master) and the block
// store (slave): row read-out, row write-back, row advance.
interface block_state_store_if;
    import block_store_pkg::*;

    row_t block_line_state;
    logic go_next_line;
    logic write_block_line_state;
    row_t new_block_line_state;

    modport master (
        output go_next_line,
        output write_block_line_state,
        output new_block_line_state,
        input  block_line_state
    );

    modport slave (
        input  go_next_line,
        input  write_block_line_state,
        input  new_block_line_state,
        output block_line_state
    );

endinterface

// File: rtl/bit_popcount.sv
// Combinational population count of one 13-bit block row.
module bit_popcount
    import block_store_pkg::*;
(
    input  row_t       bits,
    output logic [3:0] count
);

    always_comb begin
        count = 4'd0;
        for (int i = 0; i < BLOCKS_PER_ROW; i++)
            count = count + {3'd0, bits[i]};
    end

endmodule

// File: rtl/block_state_store.sv
// Breakout block map, served row by row to the painter, with a
// frame-aligned level reload. BLOCK_STORE_COUNT_EN adds the counter.
module block_state_store
    import block_store_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    block_state_store_if.slave        line,
    input  logic                      level_reload,
    output logic                      reload_busy,
    output logic [7:0]                blocks_remaining,
    output logic                      all_cleared
);

    row_t     mem [NUM_ROWS];
    row_idx_t row_idx;
    row_idx_t row_next;
    row_idx_t fill_cnt;
    row_t     bls_q;
    fsm_t     state;
    logic     fill_start;
    logic     wr_ok;

    assign row_next   = row_idx + 4'd1;
    assign fill_start = (state == ARMED) && line.go_next_line &&
                        (row_idx == 4'd15);
    assign wr_ok      = line.write_block_line_state &&
                        (state != FILL);

    assign line.block_line_state = bls_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fill_cnt    <= 4'd0;
            reload_busy <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (level_reload) begin
                        state       <= ARMED;
                        reload_busy <= 1'b1;
                    end
                end
                ARMED: begin
                    if (fill_start) begin
                        state    <= FILL;
                        fill_cnt <= 4'd0;
                    end
                end
                FILL: begin
                    fill_cnt <= fill_cnt + 4'd1;
                    if (fill_cnt == 4'd15) begin
                        state       <= IDLE;
                        reload_busy <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    reload_busy <= 1'b0;
                end
            endcase
        end
    end

    // Rows not yet refilled may still hold old data, so the output
    // is forced full from the reload edge until FILL finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ROWS; i++)
                mem[i] <= FULL_ROW;
            row_idx <= 4'd0;
            bls_q   <= FULL_ROW;
        end else begin
            if (state == FILL)
                mem[fill_cnt] <= FULL_ROW;
            else if (wr_ok)
                mem[row_idx] <= line.new_block_line_state;
            if (line.go_next_line) begin
                row_idx <= row_next;
                if (fill_start || (state == FILL))
                    bls_q <= FULL_ROW;
                else
                    bls_q <= mem[row_next];
            end
        end
    end

`ifdef BLOCK_STORE_COUNT_EN
    row_t       cleared;
    logic [3:0] dec;
    logic [7:0] cnt_q;

    assign cleared = mem[row_idx] & ~line.new_block_line_state;

    bit_popcount u_popcount (
        .bits  (cleared),
        .count (dec)
    );

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= TOTAL_BLOCKS;
        else if (fill_start)
            cnt_q <= TOTAL_BLOCKS;
        else if (wr_ok) begin
            if (cnt_q < {4'd0, dec})
                cnt_q <= 8'd0;
            else
                cnt_q <= cnt_q - {4'd0, dec};
        end
    end

    assign blocks_remaining = cnt_q;
    assign all_cleared      = (cnt_q == 8'd0) && (state == IDLE);
`else
    assign blocks_remaining = 8'd0;
    assign all_cleared      = 1'b0;
`endif

endmodule

// File: tb/tb_block_state_store.sv
// Directed bench for block_state_store: map serving, write-back,
// counting, deferred reload, FILL behaviour and reset during FILL.
module tb_block_state_store;
    import block_store_pkg::*;

`ifdef BLOCK_STORE_COUNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       level_reload;
    logic       reload_busy;
    logic [7:0] blocks_remaining;
    logic       all_cleared;

    int errors;
    int checks;
    int ptr;

    block_state_store_if line ();

    block_state_store dut (
        .clk              (clk),
        .rst              (rst),
        .line             (line.slave),
        .level_reload     (level_reload),
        .reload_busy      (reload_busy),
        .blocks_remaining (blocks_remaining),
        .all_cleared      (all_cleared)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_cnt(int v);
        return CNT ? 8'(v) : 8'd0;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go;
        line.go_next_line = 1'b1;
        step();
        line.go_next_line = 1'b0;
        ptr = (ptr + 1) % 16;
    endtask

    task automatic write_row(input row_t v);
        line.write_block_line_state = 1'b1;
        line.new_block_line_state   = v;
        step();
        line.write_block_line_state = 1'b0;
    endtask

    task automatic goto_row(input int r);
        for (int k = 0; k < 16 && ptr != r; k++)
            pulse_go();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        ptr = 0;
        checks++;
        if (line.block_line_state !== FULL_ROW) begin
            errors++;
            $display("FAIL reset_bls got=%h exp=%h",
                     line.block_line_state, FULL_ROW);
        end
        checks++;
        if (blocks_remaining !== exp_cnt(208)) begin
            errors++;
            $display("FAIL reset_cnt got=%0d exp=%0d",
                     blocks_remaining, exp_cnt(208));
        end
        checks++;
        if (all_cleared !== 1'b0) begin
            errors++;
            $display("FAIL reset_clr got=%b exp=0", all_cleared);
        end
        checks++;
        if (reload_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b exp=0", reload_busy);
        end
        for (int i = 0; i < 16; i++) begin
            pulse_go();
            checks++;
            if (line.block_line_state !== FULL_ROW) begin
                errors++;
                $display("FAIL scan_full row=%0d got=%h exp=%h",
                         ptr, line.block_line_state, FULL_ROW);
            end
        end
    endtask

    task automatic test_write_row3;
        goto_row(3);
        write_row(13'h1FFB);
        checks++;
        if (blocks_remaining !== exp_cnt(207)) begin
            errors++;
            $display("FAIL w3_cnt got=%0d exp=%0d",
                     blocks_remaining, exp_cnt(207));
        end
        pulse_go();
        checks++;
        if (line.block_line_state !== FULL_ROW) begin
            errors++;
            $display("FAIL w3_row4 got=%h exp=%h",
                     line.block_line_state, FULL_ROW);
        end
        goto_row(3);
        checks++;
        if (line.block_line_state !== 13'h1FFB) begin
            errors++;
            $display("FAIL w3_back got=%h exp=1ffb",
                     line.block_line_state);
        end
        write_row(13'h1FFB);
        checks++;
        if (blocks_remaining !== exp_cnt(207)) begin
            errors++;
            $display("FAIL w3_same got=%0d exp=%0d",
                     blocks_remaining, exp_cnt(207));
        end
        write_row(13'h1FFF);
        checks++;
        if (blocks_remaining !== exp_cnt(207)) begin
            errors++;
            $display("FAIL w3_setbit got=%0d exp=%0d",
                     blocks_remaining, exp_cnt(207));
        end
    endtask

    task automatic test_clear_all;
        for (int i = 0; i < 16; i++) begin
            write_row(13'h0000);
            if (i == 14) begin
                checks++;
                if (blocks_remaining !== exp_cnt(12)) begin
                    errors++;
                    $display("FAIL clr_15 got=%0d exp=%0d",
                             blocks_remaining, exp_cnt(12));
                end
                checks++;
                if (all_cleared !== 1'b0) begin
                    errors++;
                    $display("FAIL clr_early got=%b exp=0",
                             all_cleared);
                end
            end
            if (i == 15) begin
                checks++;
                if (blocks_remaining !== 8'd0) begin
                    errors++;
                    $display("FAIL clr_sat got=%0d exp=0",
                             blocks_remaining);
                end
                checks++;
                if (all_cleared !== CNT) begin
                    errors++;
                    $display("FAIL clr_all got=%b exp=%b",
                             all_cleared, CNT);
                end
            end
            pulse_go();
        end
        checks++;
        if (line.block_line_state !== 13'h0000) begin
            errors++;
            $display("FAIL clr_row3 got=%h exp=0000",
                     line.block_line_state);
        end
    endtask

    task automatic test_reload;
        goto_row(7);
        level_reload = 1'b1;
        step();
        level_reload = 1'b0;
        checks++;
        if (reload_busy !== 1'b1) begin
            errors++;
            $display("FAIL rl_busy got=%b exp=1", reload_busy);
        end
        checks++;
        if (all_cleared !== 1'b0) begin
            errors++;
            $display("FAIL rl_armclr got=%b exp=0", all_cleared);
        end
        level_reload = 1'b1;
        step();
        level_reload = 1'b0;
        goto_row(15);
        checks++;
        if (line.block_line_state !== 13'h0000) begin
            errors++;
            $display("FAIL rl_armed_map got=%h exp=0000",
                     line.block_line_state);
        end
        checks++;
        if (blocks_remaining !== 8'd0 || reload_busy !== 1'b1) begin
            errors++;
            $display("FAIL rl_armed cnt=%0d busy=%b exp=0/1",
                     blocks_remaining, reload_busy);
        end
        write_row(13'h0000);
        pulse_go();
        checks++;
        if (line.block_line_state !== FULL_ROW) begin
            errors++;
            $display("FAIL rl_t2 got=%h exp=%h",
                     line.block_line_state, FULL_ROW);
        end
        checks++;
        if (blocks_remaining !== exp_cnt(208)) begin
            errors++;
            $display("FAIL rl_cnt got=%0d exp=%0d",
                     blocks_remaining, exp_cnt(208));
        end
        step();
        line.go_next_line = 1'b1;
        write_row(13'h0000);
        line.go_next_line = 1'b0;
        ptr = (ptr + 1) % 16;
        checks++;
        if (line.block_line_state !== FULL_ROW) begin
            errors++;
            $display("FAIL fill_wgo got=%h exp=%h",
                     line.block_line_state, FULL_ROW);
        end
        checks++;
        if (blocks_remaining !== exp_cnt(208)) begin
            errors++;
            $display("FAIL fill_drop_cnt got=%0d exp=%0d",
                     blocks_remaining, exp_cnt(208));
        end
        pulse_go();
        checks++;
        if (line.block_line_state !== FULL_ROW) begin
            errors++;
            $display("FAIL fill_force got=%h exp=%h",
                     line.block_line_state, FULL_ROW);
        end
        level_reload = 1'b1;
        step();
        level_reload = 1'b0;
        for (int i = 0; i < 11; i++)
            step();
        checks++;
        if (reload_busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_busy15 got=%b exp=1", reload_busy);
        end
        step();
        checks++;
        if (reload_busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_done got=%b exp=0", reload_busy);
        end
        checks++;
        if (all_cleared !== 1'b0) begin
            errors++;
            $display("FAIL fill_clr got=%b exp=0", all_cleared);
        end
        for (int i = 0; i < 16; i++) begin
            pulse_go();
            checks++;
            if (line.block_line_state !== FULL_ROW) begin
                errors++;
                $display("FAIL refill row=%0d got=%h exp=%h",
                         ptr, line.block_line_state, FULL_ROW);
            end
        end
    endtask

    task automatic test_reset_in_fill;
        goto_row(0);
        write_row(13'h0000);
        checks++;
        if (blocks_remaining !== exp_cnt(195)) begin
            errors++;
            $display("FAIL rf_cnt got=%0d exp=%0d",
                     blocks_remaining, exp_cnt(195));
        end
        goto_row(9);
        write_row(13'h0F0F);
        level_reload = 1'b1;
        step();
        level_reload = 1'b0;
        goto_row(15);
        pulse_go();
        for (int i = 0; i < 4; i++)
            step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ptr = 0;
        checks++;
        if (line.block_line_state !== FULL_ROW) begin
            errors++;
            $display("FAIL rf_bls got=%h exp=%h",
                     line.block_line_state, FULL_ROW);
        end
        checks++;
        if (blocks_remaining !== exp_cnt(208)) begin
            errors++;
            $display("FAIL rf_rcnt got=%0d exp=%0d",
                     blocks_remaining, exp_cnt(208));
        end
        checks++;
        if (reload_busy !== 1'b0) begin
            errors++;
            $display("FAIL rf_busy got=%b exp=0", reload_busy);
        end
        for (int i = 0; i < 16; i++) begin
            pulse_go();
            checks++;
            if (line.block_line_state !== FULL_ROW) begin
                errors++;
                $display("FAIL rf_map row=%0d got=%h exp=%h",
                         ptr, line.block_line_state, FULL_ROW);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ptr = 0;
        rst = 1'b1;
        level_reload = 1'b0;
        line.go_next_line = 1'b0;
        line.write_block_line_state = 1'b0;
        line.new_block_line_state = '0;
        test_reset();
        test_write_row3();
        test_clear_all();
        test_reload();
        test_reset_in_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
